// File: rtl/fpga80186_pkg.sv
// Shared types and bus-width defaults for the fpga80186 memory subsystem.
package fpga80186_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CPU_XFER,
        VGA_XFER,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// CPU/VGA single-port memory arbiter: VGA priority, CPU anti-starvation.
// Define MEM_ARB_TIMEOUT_EN to enable the transfer watchdog and mem_err.
module mem_arbiter
    import fpga80186_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk_cpu,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              mem_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(CPU_MAX_WAIT);

    arb_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]     vga_rdata_q, vga_rdata_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  vga_ready_q, vga_ready_d;

    logic                  cpu_win;
    logic                  vga_win;
    logic                  xfer_end;
    logic [DATA_W-1:0]     xfer_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'd254;

    logic [7:0]            tmo_q, tmo_d;
    logic                  err_q, err_d;
`endif

    // VGA normally wins a tie; a CPU that has lost too often is forced through.
    assign cpu_win = cpu_req && (!vga_req || (wait_q >= WAIT_LIM));
    assign vga_win = vga_req && !cpu_win;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        cpu_ready_d = 1'b0;
        vga_ready_d = 1'b0;
        xfer_end    = 1'b0;
        xfer_data   = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif

        if (!cpu_req) begin
            wait_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    cpu_win: begin
                        state_d     = CPU_XFER;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        wait_d      = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                    vga_win: begin
                        state_d     = VGA_XFER;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = vga_addr;
                        mem_wdata_d = '0;
                        if (cpu_req && (wait_q != WAIT_MAX)) begin
                            wait_d = wait_q + 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                    default: begin
                    end
                endcase
            end

            CPU_XFER, VGA_XFER: begin
                if (mem_ack) begin
                    xfer_end = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // 255th cycle without ack: abort with poisoned data.
                    xfer_end  = 1'b1;
                    xfer_data = '1;
                    err_d     = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
                if (xfer_end) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (state_q == CPU_XFER) begin
                        cpu_rdata_d = xfer_data;
                        cpu_ready_d = 1'b1;
                    end else begin
                        vga_rdata_d = xfer_data;
                        vga_ready_d = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            vga_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            vga_ready_q <= vga_ready_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign vga_rdata = vga_rdata_q;
    assign vga_ready = vga_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
